// File: rtl/actor_motion_ctrl.sv
// Sprite motion controller: grid-aligned turning, clamped movement, walk animation
// and a WAKE -> ALIVE -> DYING life cycle, all paced by startOfFrame.
module actor_motion_ctrl #(
    parameter int OBJECT_WIDTH_X = 32,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int START_X = 32,
    parameter int START_Y = 160,
    parameter int MIN_X = 0,
    parameter int MAX_X = 607,
    parameter int MIN_Y = 32,
    parameter int MAX_Y = 447,
    parameter int GRID = 32,
    parameter int STEP = 2,
    parameter int NUM_FRAMES = 3,
    parameter int FRAME_DIV = 4,
    parameter int WAKE_FRAMES = 30,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftArrow,
    input  logic        rightArrow,
    input  logic        upArrow,
    input  logic        downArrow,
    input  logic        collision,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  direction,
    output logic        awake,
    output logic        dying,
    output logic [2:0]  frame,
    output logic        insideRect,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [1:0]  dbg_state
);

    localparam int WCW = $clog2(WAKE_FRAMES + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);
    localparam int FDW = $clog2(FRAME_DIV + 1);
    localparam logic signed [12:0] C_MIN_X = 13'(MIN_X);
    localparam logic signed [12:0] C_MAX_X = 13'(MAX_X);
    localparam logic signed [12:0] C_MIN_Y = 13'(MIN_Y);
    localparam logic signed [12:0] C_MAX_Y = 13'(MAX_Y);
    localparam logic signed [12:0] C_STEP  = 13'(STEP);

    typedef enum logic [1:0] {
        S_WAKE  = 2'd0,
        S_ALIVE = 2'd1,
        S_DYING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [10:0]      r_tlx;
    logic [10:0]      r_tly;
    logic [1:0]       r_dir;
    logic [2:0]       r_frame;
    logic [FDW-1:0]   r_div;
    logic [WCW-1:0]   r_wake_cnt;
    logic [DCW-1:0]   r_death_cnt;
    logic             r_inside;
    logic [10:0]      r_offx;
    logic [10:0]      r_offy;

    logic             w_wake_done;
    logic             w_death_done;
    logic             w_req_valid;
    logic [1:0]       w_req_dir;
    logic [10:0]      w_grid_x;
    logic [10:0]      w_grid_y;
    logic             w_aligned;
    logic [1:0]       w_new_dir;
    logic signed [12:0] w_cx_s;
    logic signed [12:0] w_cy_s;
    logic signed [12:0] w_nx_s;
    logic signed [12:0] w_ny_s;
    logic [10:0]      w_nx;
    logic [10:0]      w_ny;
    logic             w_moving;
    logic             w_do_move;
    logic [11:0]      w_px12;
    logic [11:0]      w_py12;
    logic             w_inside;

    assign w_wake_done  = startOfFrame && (r_wake_cnt == WCW'(WAKE_FRAMES - 1));
    assign w_death_done = startOfFrame && (r_death_cnt == DCW'(DEATH_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_WAKE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAKE:  if (w_wake_done) w_next_state = S_ALIVE;
            S_ALIVE: if (collision) w_next_state = S_DYING;
            S_DYING: if (w_death_done) w_next_state = S_WAKE;
            default: w_next_state = S_WAKE;
        endcase
    end

    // Highest-priority arrow wins; a perpendicular turn waits for a grid corner.
    always_comb begin
        w_req_valid = rightArrow | leftArrow | upArrow | downArrow;
        if (rightArrow)     w_req_dir = 2'd0;
        else if (leftArrow) w_req_dir = 2'd1;
        else if (upArrow)   w_req_dir = 2'd2;
        else                w_req_dir = 2'd3;

        w_grid_x  = r_tlx - 11'(MIN_X);
        w_grid_y  = r_tly - 11'(MIN_Y);
        w_aligned = ((w_grid_x % 11'(GRID)) == 11'd0) && ((w_grid_y % 11'(GRID)) == 11'd0);
        w_new_dir = ((w_req_dir[1] == r_dir[1]) || w_aligned) ? w_req_dir : r_dir;

        w_cx_s = $signed({2'b00, r_tlx});
        w_cy_s = $signed({2'b00, r_tly});
        w_nx_s = w_cx_s;
        w_ny_s = w_cy_s;
        case (w_new_dir)
            2'd0:    w_nx_s = w_cx_s + C_STEP;
            2'd1:    w_nx_s = w_cx_s - C_STEP;
            2'd2:    w_ny_s = w_cy_s - C_STEP;
            default: w_ny_s = w_cy_s + C_STEP;
        endcase

        if (w_nx_s < C_MIN_X)      w_nx = 11'(MIN_X);
        else if (w_nx_s > C_MAX_X) w_nx = 11'(MAX_X);
        else                       w_nx = w_nx_s[10:0];
        if (w_ny_s < C_MIN_Y)      w_ny = 11'(MIN_Y);
        else if (w_ny_s > C_MAX_Y) w_ny = 11'(MAX_Y);
        else                       w_ny = w_ny_s[10:0];

        w_moving  = (w_nx != r_tlx) || (w_ny != r_tly);
        w_do_move = (r_state == S_ALIVE) && startOfFrame && !collision && w_req_valid;
    end

    always_comb begin
        w_px12   = {1'b0, pixelX};
        w_py12   = {1'b0, pixelY};
        w_inside = (w_px12 >= {1'b0, r_tlx}) && (w_px12 < ({1'b0, r_tlx} + 12'(OBJECT_WIDTH_X))) &&
                   (w_py12 >= {1'b0, r_tly}) && (w_py12 < ({1'b0, r_tly} + 12'(OBJECT_HEIGHT_Y)));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tlx       <= 11'(START_X);
            r_tly       <= 11'(START_Y);
            r_dir       <= 2'd0;
            r_frame     <= 3'd0;
            r_div       <= '0;
            r_wake_cnt  <= '0;
            r_death_cnt <= '0;
            r_inside    <= 1'b0;
            r_offx      <= 11'd0;
            r_offy      <= 11'd0;
        end else begin
            r_inside <= w_inside;
            r_offx   <= w_inside ? (pixelX - r_tlx) : 11'd0;
            r_offy   <= w_inside ? (pixelY - r_tly) : 11'd0;
            case (r_state)
                S_WAKE: begin
                    if (startOfFrame) begin
                        r_wake_cnt <= w_wake_done ? '0 : r_wake_cnt + WCW'(1);
                    end
                end
                S_ALIVE: begin
                    if (w_do_move) begin
                        r_tlx <= w_nx;
                        r_tly <= w_ny;
                        r_dir <= w_new_dir;
                        if (w_moving) begin
                            if (r_div == FDW'(FRAME_DIV - 1)) begin
                                r_div   <= '0;
                                r_frame <= (r_frame == 3'(NUM_FRAMES - 1)) ? 3'd0 : r_frame + 3'd1;
                            end else begin
                                r_div <= r_div + FDW'(1);
                            end
                        end
                    end
                end
                S_DYING: begin
                    if (w_death_done) begin
                        r_death_cnt <= '0;
                        r_tlx       <= 11'(START_X);
                        r_tly       <= 11'(START_Y);
                        r_dir       <= 2'd0;
                        r_frame     <= 3'd0;
                        r_div       <= '0;
                    end else if (startOfFrame) begin
                        r_death_cnt <= r_death_cnt + DCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign topLeftX   = r_tlx;
    assign topLeftY   = r_tly;
    assign direction  = r_dir;
    assign frame      = r_frame;
    assign awake      = (r_state == S_ALIVE);
    assign dying      = (r_state == S_DYING);
    assign insideRect = r_inside;
    assign offsetX    = r_offx;
    assign offsetY    = r_offy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_actor_motion_ctrl.sv
// Bench for actor_motion_ctrl: directed vector table, pixel table, mid-dying reset,
// then random frames checked every cycle against an integer reference model.
module tb_actor_motion_ctrl;

    localparam int SX = 32, SY = 160, MINX = 0, MAXX = 607, MINY = 32, MAXY = 447;
    localparam int GRIDP = 32, STP = 2, NFR = 3, FDIV = 4, WAKEF = 30, DEATHF = 60;
    localparam int M_WAKE = 0, M_ALIVE = 1, M_DYING = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        leftArrow = 1'b0, rightArrow = 1'b0, upArrow = 1'b0, downArrow = 1'b0;
    logic        collision = 1'b0;
    logic [10:0] pixelX = 11'd0, pixelY = 11'd0;
    logic [10:0] topLeftX, topLeftY, offsetX, offsetY;
    logic [1:0]  direction, dbg_state;
    logic        awake, dying, insideRect;
    logic [2:0]  frame;

    actor_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .leftArrow(leftArrow), .rightArrow(rightArrow), .upArrow(upArrow), .downArrow(downArrow),
        .collision(collision), .pixelX(pixelX), .pixelY(pixelY),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .direction(direction),
        .awake(awake), .dying(dying), .frame(frame), .insideRect(insideRect),
        .offsetX(offsetX), .offsetY(offsetY), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: life phase, position, heading, animation, counters
    int m_state, m_x, m_y, m_dir, m_frame, m_div, m_wcnt, m_dcnt, m_in, m_ox, m_oy;

    typedef struct {
        logic [3:0] arr;   // {right, left, up, down}
        bit         coll;
        int         frames;
        int         ex, ey, edir, eawake, edying, eframe;
    } vec_t;

    typedef struct {
        int px, py, ein, eox, eoy;
    } pix_t;

    vec_t vecs[19];
    pix_t pix[6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_WAKE; m_x = SX; m_y = SY; m_dir = 0; m_frame = 0;
        m_div = 0; m_wcnt = 0; m_dcnt = 0; m_in = 0; m_ox = 0; m_oy = 0;
    endtask

    task automatic model_move(input logic [3:0] arr);
        int req, nd, nx, ny;
        bit on_grid;
        if (arr == 4'b0000) return;
        req = arr[3] ? 0 : arr[2] ? 1 : arr[1] ? 2 : 3;
        on_grid = ((m_x - MINX) % GRIDP == 0) && ((m_y - MINY) % GRIDP == 0);
        nd = (((req < 2) == (m_dir < 2)) || on_grid) ? req : m_dir;
        nx = m_x; ny = m_y;
        if (nd == 0) nx = nx + STP;
        else if (nd == 1) nx = nx - STP;
        else if (nd == 2) ny = ny - STP;
        else ny = ny + STP;
        if (nx < MINX) nx = MINX;
        if (nx > MAXX) nx = MAXX;
        if (ny < MINY) ny = MINY;
        if (ny > MAXY) ny = MAXY;
        m_dir = nd;
        if (nx != m_x || ny != m_y) begin
            m_div++;
            if (m_div == FDIV) begin
                m_div = 0;
                m_frame = (m_frame + 1) % NFR;
            end
        end
        m_x = nx; m_y = ny;
    endtask

    task automatic model_clock(input bit sof, input logic [3:0] arr, input bit coll, input int px, input int py);
        m_in = (px >= m_x && px < m_x + 32 && py >= m_y && py < m_y + 32) ? 1 : 0;
        m_ox = m_in ? px - m_x : 0;
        m_oy = m_in ? py - m_y : 0;
        if (m_state == M_ALIVE && coll) begin
            m_state = M_DYING;
            m_dcnt = 0;
        end else if (sof) begin
            if (m_state == M_WAKE) begin
                m_wcnt++;
                if (m_wcnt == WAKEF) begin m_wcnt = 0; m_state = M_ALIVE; end
            end else if (m_state == M_ALIVE) begin
                model_move(arr);
            end else begin
                m_dcnt++;
                if (m_dcnt == DEATHF) begin
                    m_dcnt = 0; m_state = M_WAKE; m_x = SX; m_y = SY;
                    m_dir = 0; m_frame = 0; m_div = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("m_topLeftX", int'(topLeftX), m_x);
        chk("m_topLeftY", int'(topLeftY), m_y);
        chk("m_direction", int'(direction), m_dir);
        chk("m_frame", int'(frame), m_frame);
        chk("m_awake", int'(awake), (m_state == M_ALIVE) ? 1 : 0);
        chk("m_dying", int'(dying), (m_state == M_DYING) ? 1 : 0);
        chk("m_insideRect", int'(insideRect), m_in);
        chk("m_offsetX", int'(offsetX), m_ox);
        chk("m_offsetY", int'(offsetY), m_oy);
    endtask

    // inputs change 1 time unit after an edge; the model steps at the edge; outputs checked 1 unit later
    task automatic cyc(input bit sof, input logic [3:0] arr, input bit coll, input int px, input int py);
        startOfFrame = sof;
        {rightArrow, leftArrow, upArrow, downArrow} = arr;
        collision = coll;
        pixelX = 11'(px);
        pixelY = 11'(py);
        @(posedge clk);
        model_clock(sof, arr, coll, px, py);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        startOfFrame = 1'b0; collision = 1'b0;
        {rightArrow, leftArrow, upArrow, downArrow} = 4'b0000;
        resetN = 1'b0;
        #2;
        model_reset();
        chk("rst_topLeftX", int'(topLeftX), 32);
        chk("rst_topLeftY", int'(topLeftY), 160);
        chk("rst_direction", int'(direction), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_awake", int'(awake), 0);
        chk("rst_dying", int'(dying), 0);
        chk("rst_insideRect", int'(insideRect), 0);
        chk("rst_offsetX", int'(offsetX), 0);
        chk("rst_offsetY", int'(offsetY), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic frames(input int n, input logic [3:0] arr, input bit coll);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, arr, coll, 0, 0);
            cyc(1'b0, arr, 1'b0, 0, 0);
        end
    endtask

    task automatic run_vec(input int idx);
        frames(vecs[idx].frames, vecs[idx].arr, vecs[idx].coll);
        chk($sformatf("v%0d_topLeftX", idx), int'(topLeftX), vecs[idx].ex);
        chk($sformatf("v%0d_topLeftY", idx), int'(topLeftY), vecs[idx].ey);
        chk($sformatf("v%0d_direction", idx), int'(direction), vecs[idx].edir);
        chk($sformatf("v%0d_awake", idx), int'(awake), vecs[idx].eawake);
        chk($sformatf("v%0d_dying", idx), int'(dying), vecs[idx].edying);
        if (vecs[idx].eframe >= 0) chk($sformatf("v%0d_frame", idx), int'(frame), vecs[idx].eframe);
    endtask

    initial begin
        logic [3:0] r_arr;
        int px, py, held_frame;

        //           arr      coll frames  x    y   dir awk dy frame
        vecs[0]  = '{4'b0000, 0,  29,  32, 160, 0, 0, 0,  0};
        vecs[1]  = '{4'b0000, 0,   1,  32, 160, 0, 1, 0,  0};
        vecs[2]  = '{4'b1000, 0,  16,  64, 160, 0, 1, 0,  1};
        vecs[3]  = '{4'b1000, 1,   1,  64, 160, 0, 0, 1,  1};
        vecs[4]  = '{4'b1000, 0,  59,  64, 160, 0, 0, 1,  1};
        vecs[5]  = '{4'b1000, 0,   1,  32, 160, 0, 0, 0,  0};
        vecs[6]  = '{4'b1000, 0,  29,  32, 160, 0, 0, 0,  0};
        vecs[7]  = '{4'b1000, 0,   1,  32, 160, 0, 1, 0,  0};
        vecs[8]  = '{4'b1000, 0,   4,  40, 160, 0, 1, 0,  1};
        vecs[9]  = '{4'b0010, 0,  12,  64, 160, 0, 1, 0, -1};
        vecs[10] = '{4'b0010, 0,   1,  64, 158, 2, 1, 0, -1};
        vecs[11] = '{4'b0010, 0,   2,  64, 154, 2, 1, 0, -1};
        vecs[12] = '{4'b0001, 0,   3,  64, 160, 3, 1, 0, -1};
        vecs[13] = '{4'b1000, 0, 271, 606, 160, 0, 1, 0,  1};
        vecs[14] = '{4'b1000, 0,   1, 607, 160, 0, 1, 0,  1};
        vecs[15] = '{4'b1000, 0,   3, 607, 160, 0, 1, 0,  1};
        vecs[16] = '{4'b0111, 0,   1, 605, 160, 1, 1, 0, -1};
        vecs[17] = '{4'b0011, 0,   1, 603, 160, 1, 1, 0, -1};
        vecs[18] = '{4'b1100, 0,   1, 605, 160, 0, 1, 0, -1};

        pix[0] = '{95, 191, 1, 31, 31};
        pix[1] = '{96, 160, 0, 0, 0};
        pix[2] = '{64, 160, 1, 0, 0};
        pix[3] = '{63, 170, 0, 0, 0};
        pix[4] = '{80, 191, 1, 16, 31};
        pix[5] = '{80, 192, 0, 0, 0};

        #1;
        do_reset();

        for (int i = 0; i <= 2; i++) run_vec(i);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 4'b0000, 1'b0, pix[i].px, pix[i].py);
            chk($sformatf("p%0d_insideRect", i), int'(insideRect), pix[i].ein);
            chk($sformatf("p%0d_offsetX", i), int'(offsetX), pix[i].eox);
            chk($sformatf("p%0d_offsetY", i), int'(offsetY), pix[i].eoy);
        end
        for (int i = 3; i <= 14; i++) run_vec(i);
        held_frame = int'(frame);
        run_vec(15);
        chk("clamp_frame_held", int'(frame), held_frame);
        for (int i = 16; i <= 18; i++) run_vec(i);

        // collision between frame ticks, then reset partway through dying
        cyc(1'b0, 4'b0000, 1'b1, 0, 0);
        chk("midframe_coll_dying", int'(dying), 1);
        frames(20, 4'b0000, 1'b0);
        chk("pre_reset_dying", int'(dying), 1);
        do_reset();
        frames(29, 4'b0000, 1'b0);
        chk("rewake_29_awake", int'(awake), 0);
        chk("rewake_29_dying", int'(dying), 0);
        frames(1, 4'b0000, 1'b0);
        chk("rewake_30_awake", int'(awake), 1);

        r_arr = 4'b1000;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) r_arr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                px = $urandom_range(0, 2047);
                py = $urandom_range(0, 2047);
            end else begin
                px = m_x - 4 + $urandom_range(0, 40);
                py = m_y - 4 + $urandom_range(0, 40);
            end
            if ($urandom_range(0, 1999) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, r_arr, $urandom_range(0, 299) == 0, px, py);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
